// File: rtl/reset_seq_pkg.sv
// Shared FSM encoding, default timing constants and counter sizing helper
// for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_HOLD,
    ST_WAIT_ACK,
    ST_GAP,
    ST_READY,
    ST_FAULT
  } seq_state_e;

  localparam int DEF_NUM_STAGES  = 3;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_GAP_CYCLES  = 4;
  localparam int DEF_ACK_TIMEOUT = 255;

  // Width able to hold max_val itself, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the
// second rising edge after rst falls.
module reset_sync (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= 1'b0;
      sync_reg <= meta_reg;
    end
  end

  assign rst_sync = sync_reg;

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES downstream reset domains in order, waiting for each
// stage's ack, and latches a fault on ack timeout or ack loss.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  ready,
  output logic                  busy,
  output logic                  fault,
  output logic [IDX_W-1:0]      fault_stage
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int GAP_W  = cnt_width(GAP_CYCLES);
  localparam int TO_W   = cnt_width(ACK_TIMEOUT);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  K_LAST    = IDX_W'(NUM_STAGES - 1);

  logic                  rst_sync;
  seq_state_e            state_reg, state_next;
  logic [IDX_W-1:0]      k_reg, k_next, k_inc, lost_idx;
  logic [IDX_W-1:0]      fault_stage_reg, fault_stage_next;
  logic [NUM_STAGES-1:0] stage_rst_reg, stage_rst_next;
  logic [NUM_STAGES-1:0] acked_reg, acked_next, lost;
  logic [HOLD_W-1:0]     hold_cnt_reg, hold_cnt_next;
  logic [GAP_W-1:0]      gap_cnt_reg, gap_cnt_next;
  logic [TO_W-1:0]       to_cnt_reg, to_cnt_next;

  reset_sync u_reset_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_sync (rst_sync)
  );

  // A stage that has acked and later drops its ack is an ack loss.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_lost
      assign lost[gi] = acked_reg[gi] & ~stage_ack[gi];
    end
  endgenerate

  always_comb begin
    lost_idx = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (lost[j]) lost_idx = IDX_W'(j);
    end
  end

  assign k_inc = k_reg + IDX_W'(1);

  always_comb begin
    state_next       = state_reg;
    k_next           = k_reg;
    stage_rst_next   = stage_rst_reg;
    acked_next       = acked_reg;
    fault_stage_next = fault_stage_reg;
    hold_cnt_next    = hold_cnt_reg;
    gap_cnt_next     = gap_cnt_reg;
    to_cnt_next      = to_cnt_reg;

    if (soft_rst_req && state_reg != ST_SYNC) begin
      state_next       = ST_HOLD;
      k_next           = '0;
      stage_rst_next   = '1;
      acked_next       = '0;
      fault_stage_next = '0;
      hold_cnt_next    = '0;
    end else begin
      case (state_reg)
        ST_SYNC: begin
          // The synchronizer's final settling cycle counts as the first hold cycle.
          if (!rst_sync) begin
            state_next    = ST_HOLD;
            hold_cnt_next = HOLD_W'(1);
          end
        end
        ST_HOLD: begin
          if (hold_cnt_reg >= HOLD_LAST) begin
            state_next        = ST_WAIT_ACK;
            k_next            = '0;
            stage_rst_next[0] = 1'b0;
            to_cnt_next       = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (|lost) begin
            state_next       = ST_FAULT;
            fault_stage_next = lost_idx;
          end else if (stage_ack[k_reg]) begin
            acked_next[k_reg] = 1'b1;
            gap_cnt_next      = '0;
            state_next        = (k_reg == K_LAST) ? ST_READY : ST_GAP;
          end else if (to_cnt_reg >= TO_LAST) begin
            state_next       = ST_FAULT;
            fault_stage_next = k_reg;
          end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
          end
        end
        ST_GAP: begin
          if (|lost) begin
            state_next       = ST_FAULT;
            fault_stage_next = lost_idx;
          end else if (gap_cnt_reg >= GAP_LAST) begin
            state_next            = ST_WAIT_ACK;
            k_next                = k_inc;
            stage_rst_next[k_inc] = 1'b0;
            to_cnt_next           = '0;
          end else begin
            gap_cnt_next = gap_cnt_reg + GAP_W'(1);
          end
        end
        ST_READY: begin
          if (|lost) begin
            state_next       = ST_FAULT;
            fault_stage_next = lost_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_SYNC;
      k_reg           <= '0;
      stage_rst_reg   <= '1;
      acked_reg       <= '0;
      fault_stage_reg <= '0;
      hold_cnt_reg    <= '0;
      gap_cnt_reg     <= '0;
      to_cnt_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      k_reg           <= k_next;
      stage_rst_reg   <= stage_rst_next;
      acked_reg       <= acked_next;
      fault_stage_reg <= fault_stage_next;
      hold_cnt_reg    <= hold_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
      to_cnt_reg      <= to_cnt_next;
    end
  end

  assign stage_rst   = stage_rst_reg;
  assign fault_stage = fault_stage_reg;
  assign ready       = (state_reg == ST_READY);
  assign fault       = (state_reg == ST_FAULT);
  assign busy        = (state_reg == ST_SYNC) || (state_reg == ST_HOLD) ||
                       (state_reg == ST_WAIT_ACK) || (state_reg == ST_GAP);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release ordering, timeout, ack loss,
// soft reset interactions and asynchronous reset assertion.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       soft_rst_req;
  logic [2:0] stage_ack;
  logic [2:0] stage_rst;
  logic       ready;
  logic       busy;
  logic       fault;
  logic [1:0] fault_stage;

  int n_checks = 0;
  int n_fail   = 0;

  reset_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .stage_ack    (stage_ack),
    .stage_rst    (stage_rst),
    .ready        (ready),
    .busy         (busy),
    .fault        (fault),
    .fault_stage  (fault_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, got, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic soft_pulse();
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    soft_rst_req = 1'b0;
    stage_ack    = 3'b000;
    step(3);
    check_val("rst stage_rst", stage_rst, 3'b111);
    check_val("rst ready", ready, 0);
    check_val("rst busy", busy, 1);
    check_val("rst fault", fault, 0);
    check_val("rst fault_stage", fault_stage, 0);

    // Normal power-up: stage 0 released on edge 18, acks 3 cycles after release.
    rst = 1'b0;
    step(17);
    check_val("seq edge17 held", stage_rst, 3'b111);
    step(1);
    check_val("seq edge18 rel0", stage_rst, 3'b110);
    step(2);
    stage_ack[0] = 1'b1;
    step(1);
    check_val("seq gap0 busy", busy, 1);
    step(4);
    check_val("seq gap0 end held", stage_rst, 3'b110);
    step(1);
    check_val("seq rel1", stage_rst, 3'b100);
    step(2);
    stage_ack[1] = 1'b1;
    step(5);
    check_val("seq gap1 end held", stage_rst, 3'b100);
    step(1);
    check_val("seq rel2", stage_rst, 3'b000);
    step(2);
    stage_ack[2] = 1'b1;
    check_val("seq pre ready", ready, 0);
    step(1);
    check_val("seq ready", ready, 1);
    check_val("seq ready busy", busy, 0);
    check_val("seq ready fault", fault, 0);

    // Ack loss on stage 0 while ready.
    stage_ack[0] = 1'b0;
    step(1);
    stage_ack[0] = 1'b1;
    check_val("loss fault", fault, 1);
    check_val("loss fault_stage", fault_stage, 0);
    check_val("loss ready", ready, 0);
    step(1);
    check_val("loss sticky", fault, 1);

    // Soft reset out of FAULT, then stage 1 never acks (unreleased stage 2 acks early).
    stage_ack = 3'b000;
    soft_pulse();
    check_val("soft stage_rst", stage_rst, 3'b111);
    check_val("soft fault clr", fault, 0);
    check_val("soft fault_stage clr", fault_stage, 0);
    check_val("soft busy", busy, 1);
    step(15);
    check_val("soft hold15", stage_rst, 3'b111);
    step(1);
    check_val("soft hold16 rel0", stage_rst, 3'b110);
    step(2);
    stage_ack = 3'b101;
    step(6);
    check_val("to rel1", stage_rst, 3'b100);
    step(254);
    check_val("to before", fault, 0);
    step(1);
    check_val("to fault", fault, 1);
    check_val("to fault_stage", fault_stage, 1);
    check_val("to stage_rst", stage_rst, 3'b100);
    check_val("to ready", ready, 0);

    // Soft reset arriving on the exact timeout cycle of stage 0.
    stage_ack = 3'b000;
    soft_pulse();
    step(16);
    check_val("coinc rel0", stage_rst, 3'b110);
    step(254);
    check_val("coinc pre fault", fault, 0);
    soft_pulse();
    check_val("coinc fault", fault, 0);
    check_val("coinc stage_rst", stage_rst, 3'b111);
    check_val("coinc busy", busy, 1);

    // Soft reset during the gap after stage 1 acked.
    step(16);
    check_val("gap1 rel0", stage_rst, 3'b110);
    step(2);
    stage_ack[0] = 1'b1;
    step(6);
    check_val("gap1 rel1", stage_rst, 3'b100);
    step(2);
    stage_ack[1] = 1'b1;
    step(2);
    check_val("gap1 in gap", stage_rst, 3'b100);
    stage_ack = 3'b000;
    soft_pulse();
    check_val("gap1 soft all", stage_rst, 3'b111);
    check_val("gap1 soft fault", fault, 0);
    step(15);
    check_val("gap1 hold15", stage_rst, 3'b111);
    step(1);
    check_val("gap1 hold16 rel0", stage_rst, 3'b110);

    // Asynchronous rst mid-WAIT_ACK, then soft request while in SYNC is ignored.
    rst = 1'b1;
    #1;
    check_val("async stage_rst", stage_rst, 3'b111);
    check_val("async busy", busy, 1);
    check_val("async fault", fault, 0);
    step(2);
    rst = 1'b0;
    soft_pulse();
    step(16);
    check_val("sync soft ign edge17", stage_rst, 3'b111);
    step(1);
    check_val("sync soft ign edge18", stage_rst, 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of downstream reset domains released in order.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles all stages stay in reset after the synchronized reset release.
REQ-003 Parameter GAP_CYCLES, default 4: cycles between one stage's ack being sampled and release of the next stage.
REQ-004 Parameter ACK_TIMEOUT, default 255: cycles a released stage may take to raise its ack before a fault.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 soft_rst_req  in  1  synchronous one-cycle request to re-run the full sequence.
REQ-008 stage_ack  in  NUM_STAGES  per-stage "out of reset and alive" level, synchronous to clk.
REQ-009 stage_rst  out  NUM_STAGES  per-stage active-high reset; bit 0 is released first.
REQ-010 ready  out  1  high when all stages are released and acked.
REQ-011 busy  out  1  high while the sequence is in progress (SYNC, HOLD, WAIT_ACK or GAP).
REQ-012 fault  out  1  sticky timeout/ack-loss indicator.
REQ-013 fault_stage  out  clog2(NUM_STAGES)  index of the stage that caused fault; 0 when fault is low.

Function
REQ-014 States: SYNC, HOLD, WAIT_ACK, GAP, READY, FAULT; stage index register k.
REQ-015 rst assertion shall force all stage_rst high immediately (asynchronously), set ready=0, busy=1, fault=0, fault_stage=0, k=0, state=SYNC.
REQ-016 rst deassertion shall pass through a 2-flop synchronizer; SYNC exits to HOLD when the synchronized reset is low, clearing the hold counter.
REQ-017 HOLD shall count HOLD_CYCLES cycles, then clear stage_rst[0] (registered) and enter WAIT_ACK with k=0; stage_rst[0] falls exactly 2+HOLD_CYCLES rising edges after rst deassertion.
REQ-018 WAIT_ACK: stage_ack[k] sampled high -> if k=NUM_STAGES-1 enter READY, else enter GAP; timeout counter cleared on entry.
REQ-019 GAP shall count GAP_CYCLES cycles, then increment k, clear stage_rst[k] and enter WAIT_ACK; the next stage releases GAP_CYCLES+1 edges after the edge that sampled the ack.
REQ-020 WAIT_ACK with no ack for ACK_TIMEOUT cycles -> FAULT, fault=1, fault_stage=k; already released stages stay released, unreleased stages stay in reset.
REQ-021 In GAP, WAIT_ACK or READY, stage_ack[j] low for any already acked stage j shall enter FAULT with fault_stage=j; lowest such j wins.
REQ-022 READY: ready=1, busy=0; held until rst, soft_rst_req or ack loss.
REQ-023 soft_rst_req in any state except SYNC shall on the next edge set all stage_rst high, clear ready, fault and fault_stage, set k=0, enter HOLD; it is ignored in SYNC.
REQ-024 soft_rst_req and an ack/timeout event in the same cycle: soft_rst_req wins.
REQ-025 stage_ack for stages not yet released shall be ignored.
REQ-026 Counters shall be sized for their parameter, never wrap, and saturate at terminal count.

Reset
REQ-027 Every flop shall reset asynchronously on rst high, except the synchronizer output flop, which shall also preset high; outputs take REQ-015 values.
REQ-028 stage_rst shall be driven directly from flops with no combinational glitch path, except the asynchronous rst assertion.

Structure
REQ-029 The state encoding and the default parameter constants shall go in a shared package, reset_seq_pkg.
REQ-030 A sub-module reset_sync (2-flop, async assert, sync deassert) shall be instantiated for REQ-016.

Verification
REQ-031 rst pulse then release, acks returned 3 cycles after each stage release -> stage_rst[0] falls at edge 18, stage_rst[1] 5 edges after ack0 is sampled, ready=1 after ack2, fault=0.
REQ-032 stage_ack[1] never rises -> fault=1, fault_stage=1 after 255 cycles in WAIT_ACK; stage_rst=3'b100, ready=0.
REQ-033 In READY, drop stage_ack[0] for 1 cycle -> FAULT next edge, fault_stage=0, ready=0.
REQ-034 soft_rst_req during GAP of stage 1 -> all stage_rst high next edge, fault cleared, stage_rst[0] falls 16 edges later.
REQ-035 rst asserted mid-WAIT_ACK -> stage_rst=3'b111 with no clock edge; soft_rst_req during SYNC is ignored.
REQ-036 soft_rst_req coincident with the timeout cycle -> HOLD entered, fault stays 0.
